// File: rtl/lcd_scene_scheduler.sv
// lcd_scene_scheduler
//   Chooses which scene the LCD shows (monitor or missed-dose) and which
//   28-bit entry it shows. Three sources share the display: the default
//   monitor scene, the missed-dose alarm, and the user-browsed missed-dose log.
//   Each missed-scene entry is fetched from the log RAM and then held for a
//   dwell that is timed in 400 Hz ticks.
//
// Optional feature: define LCD_LOG_AUTOSCROLL_EN to make dwell expiry in log
//   mode advance to the next entry, just as log_step does. Without it, dwell
//   expiry in log mode returns to the monitor scene.
//
// Ports
//   clk        in   system clock; the only clock
//   reset      in   synchronous, active-high reset
//   tick       in   one-cycle 400 Hz time-base strobe
//   alarm_req  in   level; a missed dose is pending
//   alarm_ack  out  one-cycle pulse when the alarm scene finishes its dwell
//   log_req    in   pulse; the user starts browsing the log
//   log_step   in   pulse; advance to the next log entry
//   log_count  in   number of valid log entries (0..2^ADDR_W)
//   ram_addr   out  log RAM read address
//   ram_rd     out  read strobe; ram_data is valid on the following cycle
//   ram_data   in   log RAM read data
//   lcd_data   out  entry shown on the LCD
//   scene_sel  out  0 = monitor scene, 1 = missed scene
//   lcd_update out  one-cycle pulse in the first cycle of a new lcd_data

module lcd_scene_scheduler #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 28,
  parameter int unsigned DWELL_TICKS = 800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              alarm_req,
  output logic              alarm_ack,
  input  logic              log_req,
  input  logic              log_step,
  input  logic [ADDR_W:0]   log_count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] lcd_data,
  output logic              scene_sel,
  output logic              lcd_update
);

  localparam int unsigned CNT_W = $clog2(DWELL_TICKS + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] DWELL_MAX  = CNT_W'(DWELL_TICKS);

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    SHOW    = 2'd3
  } state_t;

  state_t            state;
  logic              alarm_mode;
  logic              zero_load;   // alarm with an empty log shows 0, not RAM
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  dwell;

  logic [ADDR_W:0]   idx_inc;
  logic              last_entry;
  logic [ADDR_W-1:0] alarm_addr;
  logic              log_empty;
  logic              dwell_done;
  logic              advance;

  // Step bookkeeping. ">=" rather than "==" so a log_count that shrank
  // mid-browse still ends the browse instead of running past the log.
  assign idx_inc    = {1'b0, idx} + (ADDR_W+1)'(1);
  assign last_entry = (idx_inc >= log_count);

  // The alarm shows the newest entry, or address 0 with a forced 0 if empty.
  assign log_empty  = (log_count == '0);
  assign alarm_addr = log_empty ? '0 : ADDR_W'(log_count - (ADDR_W+1)'(1));

  // The dwell expires on the tick that would bring the count to DWELL_TICKS.
  assign dwell_done = tick && (dwell >= DWELL_LAST);

`ifdef LCD_LOG_AUTOSCROLL_EN
  assign advance = log_step || dwell_done;
`else
  assign advance = log_step;
`endif

  // Scene sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= MONITOR;
      alarm_mode <= 1'b0;
      zero_load  <= 1'b0;
      idx        <= '0;
      dwell      <= '0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
      lcd_data   <= '0;
      scene_sel  <= 1'b0;
      lcd_update <= 1'b0;
      alarm_ack  <= 1'b0;
    end else begin
      ram_rd     <= 1'b0;
      lcd_update <= 1'b0;
      alarm_ack  <= 1'b0;

      case (state)
        MONITOR: begin
          dwell <= '0;
          // The alarm has priority; a simultaneous log_req is dropped.
          if (alarm_req) begin
            state      <= FETCH;
            alarm_mode <= 1'b1;
            zero_load  <= log_empty;
            ram_addr   <= alarm_addr;
            ram_rd     <= 1'b1;
            scene_sel  <= 1'b1;
          end else if (log_req && !log_empty) begin
            state      <= FETCH;
            alarm_mode <= 1'b0;
            zero_load  <= 1'b0;
            idx        <= '0;
            ram_addr   <= '0;
            ram_rd     <= 1'b1;
            scene_sel  <= 1'b1;
          end
        end

        FETCH: begin
          state <= CAPTURE;
        end

        CAPTURE: begin
          lcd_data   <= zero_load ? '0 : ram_data;
          lcd_update <= 1'b1;
          dwell      <= '0;
          state      <= SHOW;
        end

        SHOW: begin
          if (alarm_mode) begin
            if (dwell_done) begin
              alarm_ack <= 1'b1;
              scene_sel <= 1'b0;
              state     <= MONITOR;
            end else if (tick && dwell != DWELL_MAX) begin
              dwell <= dwell + CNT_W'(1);
            end
          end else if (alarm_req) begin
            // Alarm preempts the browse; the browse position is abandoned.
            state      <= FETCH;
            alarm_mode <= 1'b1;
            zero_load  <= log_empty;
            ram_addr   <= alarm_addr;
            ram_rd     <= 1'b1;
          end else if (advance) begin
            // A step taken together with a tick swallows the tick.
            if (last_entry) begin
              scene_sel <= 1'b0;
              state     <= MONITOR;
            end else begin
              idx      <= ADDR_W'(idx_inc);
              ram_addr <= ADDR_W'(idx_inc);
              ram_rd   <= 1'b1;
              state    <= FETCH;
            end
          end else if (dwell_done) begin
            scene_sel <= 1'b0;
            state     <= MONITOR;
          end else if (tick && dwell != DWELL_MAX) begin
            dwell <= dwell + CNT_W'(1);
          end
        end

        default: begin
          state <= MONITOR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_scene_scheduler.sv
// Directed bench for lcd_scene_scheduler with DWELL_TICKS=4 and a one-cycle
// latency log RAM model. Expected values are hand-computed constants.

module tb_lcd_scene_scheduler;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 28;
  localparam int unsigned DWELL  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              tick = 1'b0;
  logic              alarm_req = 1'b0;
  logic              alarm_ack;
  logic              log_req = 1'b0;
  logic              log_step = 1'b0;
  logic [ADDR_W:0]   log_count = 5'd3;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [DATA_W-1:0] ram_data = '0;
  logic [DATA_W-1:0] lcd_data;
  logic              scene_sel;
  logic              lcd_update;

  logic [DATA_W-1:0] mem [16];

  int n_checks = 0;
  int n_pass   = 0;

  lcd_scene_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DWELL_TICKS(DWELL)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .alarm_req(alarm_req), .alarm_ack(alarm_ack),
    .log_req(log_req), .log_step(log_step), .log_count(log_count),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_data(ram_data),
    .lcd_data(lcd_data), .scene_sel(scene_sel), .lcd_update(lcd_update)
  );

  always #5 clk = ~clk;

  // Log RAM: data for a read strobe appears the following cycle.
  always @(posedge clk) begin
    if (ram_rd) ram_data <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // n consecutive tick strobes; returns just after the last sampled tick.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  // Starts a browse and returns in the first SHOW cycle.
  task automatic start_log(input string tag);
    log_req = 1'b1;
    cyc();
    log_req = 1'b0;
    check({tag, "_rd"}, 32'(ram_rd), 32'd1);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    cyc();
    cyc();
    check({tag, "_data"}, 32'(lcd_data), 32'h1111111);
  endtask

  // One log_step that should fetch addr and show data three cycles later.
  task automatic step_to(input string tag, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data);
    log_step = 1'b1;
    cyc();
    log_step = 1'b0;
    check({tag, "_rd"}, 32'(ram_rd), 32'd1);
    check({tag, "_addr"}, 32'(ram_addr), 32'(addr));
    cyc();
    cyc();
    check({tag, "_data"}, 32'(lcd_data), 32'(data));
    check({tag, "_upd"}, 32'(lcd_update), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 28'hBAD0000 + 28'(i);
    mem[0] = 28'h1111111;
    mem[1] = 28'h2222222;
    mem[2] = 28'h3333333;

    // Reset values
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_scene", 32'(scene_sel), 32'd0);
    check("rst_rd", 32'(ram_rd), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_data", 32'(lcd_data), 32'd0);
    check("rst_upd", 32'(lcd_update), 32'd0);
    check("rst_ack", 32'(alarm_ack), 32'd0);

    // Log browse: request, two steps, third step exits
    log_req = 1'b1;
    cyc();
    log_req = 1'b0;
    check("log_rd", 32'(ram_rd), 32'd1);
    check("log_addr", 32'(ram_addr), 32'd0);
    check("log_scene", 32'(scene_sel), 32'd1);
    cyc();
    check("log_rd_once", 32'(ram_rd), 32'd0);
    cyc();
    check("log_data0", 32'(lcd_data), 32'h1111111);
    check("log_upd0", 32'(lcd_update), 32'd1);
    cyc();
    check("log_upd_once", 32'(lcd_update), 32'd0);
    step_to("step1", 4'd1, 28'h2222222);
    step_to("step2", 4'd2, 28'h3333333);
    log_step = 1'b1;
    cyc();
    log_step = 1'b0;
    check("step3_scene", 32'(scene_sel), 32'd0);
    check("step3_rd", 32'(ram_rd), 32'd0);
    check("step3_hold", 32'(lcd_data), 32'h3333333);

    // Alarm preempts a log browse and shows the newest entry
    start_log("pre_log");
    alarm_req = 1'b1;
    cyc();
    check("alm_rd", 32'(ram_rd), 32'd1);
    check("alm_addr", 32'(ram_addr), 32'd2);
    cyc();
    cyc();
    check("alm_data", 32'(lcd_data), 32'h3333333);
    log_step = 1'b1;
    cyc();
    log_step = 1'b0;
    check("alm_step_ign_scene", 32'(scene_sel), 32'd1);
    check("alm_step_ign_rd", 32'(ram_rd), 32'd0);
    ticks(3);
    check("alm_t3_ack", 32'(alarm_ack), 32'd0);
    check("alm_t3_scene", 32'(scene_sel), 32'd1);
    ticks(1);
    check("alm_ack", 32'(alarm_ack), 32'd1);
    check("alm_done_scene", 32'(scene_sel), 32'd0);
    alarm_req = 1'b0;
    cyc();
    check("alm_ack_once", 32'(alarm_ack), 32'd0);
    check("alm_no_reenter", 32'(ram_rd), 32'd0);

    // Empty log: log_req ignored, alarm shows 0
    log_count = 5'd0;
    log_req = 1'b1;
    cyc();
    log_req = 1'b0;
    check("empty_log_rd", 32'(ram_rd), 32'd0);
    check("empty_log_scene", 32'(scene_sel), 32'd0);
    alarm_req = 1'b1;
    cyc();
    check("empty_alm_addr", 32'(ram_addr), 32'd0);
    check("empty_alm_rd", 32'(ram_rd), 32'd1);
    cyc();
    cyc();
    check("empty_alm_data", 32'(lcd_data), 32'd0);
    check("empty_alm_upd", 32'(lcd_update), 32'd1);
    ticks(4);
    check("empty_alm_ack", 32'(alarm_ack), 32'd1);
    alarm_req = 1'b0;
    log_count = 5'd3;
    cyc();

    // Simultaneous alarm_req and log_req: alarm wins
    alarm_req = 1'b1;
    log_req = 1'b1;
    cyc();
    log_req = 1'b0;
    check("tie_req_addr", 32'(ram_addr), 32'd2);
    cyc();
    cyc();
    check("tie_req_data", 32'(lcd_data), 32'h3333333);
    ticks(4);
    check("tie_req_ack", 32'(alarm_ack), 32'd1);
    alarm_req = 1'b0;
    cyc();

    // Dwell expiry in log mode
    start_log("dw_log");
    ticks(3);
    check("dw_t3_scene", 32'(scene_sel), 32'd1);
    ticks(1);
`ifdef LCD_LOG_AUTOSCROLL_EN
    check("dw_auto_rd", 32'(ram_rd), 32'd1);
    check("dw_auto_addr", 32'(ram_addr), 32'd1);
    cyc();
    cyc();
    check("dw_auto_data1", 32'(lcd_data), 32'h2222222);
    ticks(4);
    check("dw_auto_addr2", 32'(ram_addr), 32'd2);
    cyc();
    cyc();
    check("dw_auto_data2", 32'(lcd_data), 32'h3333333);
    ticks(4);
    check("dw_auto_exit", 32'(scene_sel), 32'd0);
`else
    check("dw_timeout_scene", 32'(scene_sel), 32'd0);
    check("dw_timeout_rd", 32'(ram_rd), 32'd0);
`endif
    cyc();

    // tick together with log_step: step wins, dwell restarts from 0
    start_log("tie_log");
    ticks(3);
    tick = 1'b1;
    log_step = 1'b1;
    cyc();
    tick = 1'b0;
    log_step = 1'b0;
    check("tie_step_rd", 32'(ram_rd), 32'd1);
    check("tie_step_addr", 32'(ram_addr), 32'd1);
    cyc();
    cyc();
    check("tie_step_data", 32'(lcd_data), 32'h2222222);
    ticks(3);
    check("tie_dwell_restart", 32'(scene_sel), 32'd1);
    ticks(1);
`ifdef LCD_LOG_AUTOSCROLL_EN
    check("tie_expiry_addr", 32'(ram_addr), 32'd2);
    cyc();
    cyc();
    log_step = 1'b1;
    cyc();
    log_step = 1'b0;
`endif
    check("tie_expiry_scene", 32'(scene_sel), 32'd0);
    cyc();

    // Reset mid-SHOW at idx=2
    start_log("rst_log");
    step_to("rst_s1", 4'd1, 28'h2222222);
    step_to("rst_s2", 4'd2, 28'h3333333);
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    check("midrst_scene", 32'(scene_sel), 32'd0);
    check("midrst_data", 32'(lcd_data), 32'd0);
    check("midrst_rd", 32'(ram_rd), 32'd0);
    check("midrst_addr", 32'(ram_addr), 32'd0);
    // Browse restarts at entry 0 after reset
    start_log("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_scene_scheduler.md
# lcd_scene_scheduler

- Decides which scene the LCD shows, and what data that scene displays, for the pill-dispenser display path.
- Three sources share the display:
  - the default monitor scene;
  - a missed-dose alarm;
  - a user-browsed log of missed doses held in RAM.
- Fetches the log entries from RAM and drives the LCD path's scene-select and 28-bit data inputs.
- Times each scene's dwell from the 400 Hz tick.

## Interface
Parameters:
- ADDR_W, 4, log RAM address width (depth 2^ADDR_W entries)
- DATA_W, 28, RAM word / LCD data width
- DWELL_TICKS, 800, ticks a scene is held (2 s at 400 Hz); must be >= 1

Ports:
- clk  in  1  system clock; sole clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle strobe, 400 Hz time base
- alarm_req  in  1  level; missed dose pending
- alarm_ack  out  1  one-cycle pulse when the alarm scene finishes its dwell
- log_req  in  1  pulse; user requests missed-dose log browse
- log_step  in  1  pulse; advance to the next log entry
- log_count  in  ADDR_W+1  number of valid log entries (0..2^ADDR_W)
- ram_addr  out  ADDR_W  log RAM read address
- ram_rd  out  1  read strobe; RAM returns ram_data the following cycle
- ram_data  in  DATA_W  RAM read data
- lcd_data  out  DATA_W  registered entry shown on the LCD
- scene_sel  out  1  0 = monitor scene, 1 = missed scene
- lcd_update  out  1  one-cycle pulse, in the first cycle lcd_data holds a new value

## Operation
States: MONITOR, FETCH, CAPTURE, SHOW. A mode flag `alarm_mode` distinguishes alarm from log. A log index `idx` is ADDR_W bits wide.

- **MONITOR**
  - scene_sel=0.
  - If alarm_req: go to FETCH with alarm_mode=1 and ram_addr = log_count-1. If log_count==0, ram_addr=0 and CAPTURE loads 0 instead of ram_data.
  - Else if log_req and log_count!=0: go to FETCH with alarm_mode=0, idx=0, ram_addr=0.
  - log_req with log_count==0 is ignored.
  - If alarm_req and log_req arrive in the same cycle, the alarm wins and log_req is dropped.
- **FETCH**
  - ram_rd=1 for exactly this cycle. Then go to CAPTURE.
- **CAPTURE**
  - Latch ram_data (or 0, see MONITOR) into lcd_data. Then go to SHOW.
  - Clear the dwell counter.
- **SHOW**
  - lcd_update=1 in the first SHOW cycle only.
  - The dwell counter increments on tick.
  - Alarm mode: when the counter reaches DWELL_TICKS, pulse alarm_ack and go to MONITOR. log_step and log_req are ignored.
  - Log mode, priority order:
    1. alarm_req: go to FETCH in alarm mode; idx is discarded.
    2. log_step: if idx+1 == log_count, go to MONITOR; else idx <= idx+1 and go to FETCH with ram_addr = idx+1.
    3. Dwell expiry: go to MONITOR (see Configuration).
  - log_req is ignored in log mode.
- scene_sel=1 in FETCH, CAPTURE and SHOW.
- lcd_data holds its last value when the block returns to MONITOR.
- If alarm_req is still high after alarm_ack, MONITOR re-enters alarm on the next cycle. The requester is expected to clear alarm_req on alarm_ack.
- The dwell counter is sized ceil(log2(DWELL_TICKS+1)) bits and saturates; it never wraps.

## Timing
- Reset values: state=MONITOR; scene_sel=0, ram_rd=0, ram_addr=0, lcd_data=0, lcd_update=0, alarm_ack=0; idx=0; dwell=0.
- Reset asserted mid-operation aborts any fetch or dwell and applies the reset values on the next edge.
- A request sampled in cycle N produces:
  - N+1: FETCH (ram_rd=1, scene_sel=1);
  - N+2: CAPTURE;
  - N+3: new lcd_data with lcd_update=1.
- A log_step sampled in cycle M gives its new entry at M+3.
- Alarm scene length is 3 + (clocks until DWELL_TICKS ticks) cycles. alarm_ack is asserted in the cycle the SHOW→MONITOR transition is taken.
- tick and log_step in the same cycle: the step wins and the tick is not counted.
- log_count changing during a browse is sampled only at each step comparison.

## Configuration
- LCD_LOG_AUTOSCROLL_EN defined: in log mode, dwell expiry acts exactly as log_step. The block advances to the next entry, or exits to MONITOR after the last entry.
- Undefined: dwell expiry in log mode returns to MONITOR (timeout). Entries advance only on log_step.
- Alarm behaviour is identical either way.

## Test plan
- **Reset:** assert reset for 2 cycles mid-SHOW (log mode, idx=2) -> next cycle MONITOR, scene_sel=0, lcd_data=0, ram_rd=0.
- **Log browse:**
  - Setup: log_count=3, RAM[0..2]=0x1111111/0x2222222/0x3333333, DWELL_TICKS=4.
  - Pulse log_req -> ram_rd at N+1 with addr 0; lcd_data=0x1111111 with lcd_update at N+3.
  - Two log_steps -> entries 2 and 3 shown. A third step -> MONITOR.
- **Alarm preemption:** alarm_req during log SHOW, log_count=3 -> ram_addr=2 fetched; after 4 ticks alarm_ack pulses once, scene_sel=0.
- **Edge cases:**
  - log_count=0: log_req is ignored.
  - alarm_req with log_count=0 -> lcd_data=0, alarm_ack after dwell.
  - alarm_req and log_req in the same cycle -> alarm mode.
- **Dwell expiry in log mode, DWELL_TICKS=4:**
  - Without LCD_LOG_AUTOSCROLL_EN: 4 ticks -> MONITOR.
  - With it: 4 ticks -> addr 1 fetched; after the last entry -> MONITOR.
- **Tie:** tick and log_step in the same cycle -> counter cleared to 0, step taken.
